imem_loader: RTL and testbench
==============================

# imem_loader

Program loader that writes the instruction memory of the 8-bit single-cycle core from a byte stream, the writer end of the fetch path. It accepts a framed byte stream (sync, length, payload, checksum) over a valid/ready handshake and issues one instruction-memory write per payload byte. It holds the datapath stopped (`cpu_run` low) until a frame loads cleanly, then releases it.

## Interface
Parameters:
- `ADDR_W`, 8: instruction-memory address width; matches the PC width.
- `TIMEOUT`, 1024: idle cycles allowed between bytes inside a frame before abort.
- `SYNC_BYTE`, 8'hA5: frame start marker.

Ports:
- `clk`  in  1: single clock, all logic on rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle request to begin a new load.
- `rx_valid`  in  1: `rx_data` holds a byte.
- `rx_data`  in  8: incoming byte.
- `rx_ready`  out  1: loader accepts a byte this cycle.
- `imem_wr_en`  out  1: instruction-memory write strobe.
- `imem_wr_addr`  out  ADDR_W: write address.
- `imem_wr_data`  out  8: instruction byte.
- `cpu_run`  out  1: datapath clock-enable/run; high only after a good load.
- `load_done`  out  1: level; last frame loaded and verified.
- `load_err`  out  1: level; last frame aborted (checksum or timeout).

## Operation
- A byte is accepted on a cycle where `rx_valid && rx_ready`. `rx_ready` is 1 in SYNC, LEN, DATA and CHK, and 0 elsewhere.
- States:
  - IDLE: reset state.
  - SYNC: bytes other than `SYNC_BYTE` are accepted and discarded. `SYNC_BYTE` goes to LEN.
  - LEN: the accepted byte is latched as N. N=0 means 256, truncated to 2^ADDR_W. Then go to DATA, with address counter=0 and sum=0.
  - DATA: each accepted byte is written at the counter address. sum += byte, mod 256, and the counter increments. After the Nth byte, go to CHK.
  - CHK: the accepted byte C is checked. If (sum + C) mod 256 == 0, go to DONE. Otherwise go to ERR.
  - DONE: `load_done`=1 and `cpu_run`=1.
  - ERR: `load_err`=1 and `cpu_run`=0.
- `start` is honoured in IDLE, DONE and ERR. It moves to SYNC, clears `load_done`, `load_err` and `cpu_run`, and takes effect on the next cycle. `start` in any other state is ignored.
- Timeout: a counter runs in LEN, DATA and CHK. It resets to 0 on every accepted byte and on entry to each state. Reaching `TIMEOUT` goes to ERR. SYNC has no timeout.
- Bytes written before an abort stay in memory. `cpu_run` stays 0 until a later frame succeeds.
- `rx_data` is ignored whenever `rx_ready`=0.

## Timing
- Reset values: state IDLE, `rx_ready`=0, `imem_wr_en`=0, `imem_wr_addr`=0, `imem_wr_data`=0, `cpu_run`=0, `load_done`=0, `load_err`=0, counters and sum 0.
- Reset asserted mid-frame returns everything to the reset values immediately, asynchronously. No further writes are issued.
- Write latency is 1 cycle. A payload byte accepted in cycle t gives registered `imem_wr_en`=1 with its addr and data in cycle t+1. `imem_wr_en` is a single-cycle pulse per byte.
- Back-to-back bytes are sustained at 1 byte/cycle, so `imem_wr_en` can be high on consecutive cycles.
- The final write (cycle after the Nth byte) overlaps the first CHK cycle. The DONE/ERR decision uses the sum including byte N.
- `cpu_run` and `load_done` rise in the cycle after the checksum byte is accepted. This is at least one cycle after the last `imem_wr_en`, so the core never fetches a stale word.
- Address counter: ADDR_W bits, no wrap within a frame, because N is bounded by 2^ADDR_W.

## Structure
- Shared package `loader_pkg`:
  - state enum (IDLE, SYNC, LEN, DATA, CHK, DONE, ERR)
  - `SYNC_BYTE` default
  - checksum width constant
- Sub-module `loader_timer`: the timeout counter, with `clear`, `enable` and a `expired` output, parameterised by `TIMEOUT`.
- FSM, byte counter, checksum accumulator and write-port registers live in `imem_loader`.

## Test plan
- Good frame: pulse `start`, then send A5, 03, 40, 55, 6A, 01. Require 3 writes (0:40, 1:55, 2:6A), each one cycle after acceptance. `load_done`=1, `cpu_run`=1, `load_err`=0.
- Bad checksum: send A5, 02, 10, 20, then 00 (correct is D0). Require 2 writes, then `load_err`=1, `cpu_run`=0, `load_done`=0.
- Sync hunting with backpressure: send 00, FF, A5, 01, 7F, 81 with `rx_valid` toggled randomly. Require junk discarded, one write 0:7F, DONE. No write on cycles with `rx_valid`=0.
- Timeout: use `TIMEOUT`=16. Send A5, 04, 11, then idle 16 cycles. Require ERR at cycle 16 after the last accept, exactly 1 write, and `rx_ready`=0 afterward.
- Reset mid-frame: deassert `reset_n` during DATA after 2 of 5 bytes. Require all outputs at reset values immediately. A following `start` and good frame loads correctly.
- Full length: LEN=00 with `ADDR_W`=8 and 256 bytes of value i. Require writes at addr 0..255, no wrap, and the checksum decision correct.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding,
// frame constants and the length-decoding helper.
package loader_pkg;

    // Loader FSM states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_LEN  = 3'd2,
        ST_DATA = 3'd3,
        ST_CHK  = 3'd4,
        ST_DONE = 3'd5,
        ST_ERR  = 3'd6
    } loader_state_e;

    // Default start-of-frame marker.
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Checksum accumulator width: the frame sum is taken modulo 256.
    localparam int CKSUM_W = 8;

    // Payload length carried by a LEN byte. Zero encodes 256, and the result
    // is clamped to the number of addressable instruction words so a frame
    // can never wrap the address counter.
    function automatic int unsigned frame_len(input logic [7:0] len_byte,
                                              input int addr_w);
        int unsigned n;
        int unsigned limit;
        n     = (len_byte == 8'd0) ? 32'd256 : {24'd0, len_byte};
        limit = 32'd1 << addr_w;
        if (n > limit) begin
            n = limit;
        end
        return n;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream receive handshake plus instruction-memory write port.
// The master side is the byte source / memory; the slave side is the loader.
interface imem_loader_if #(
    parameter int ADDR_W = 8
) ();

    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              imem_wr_en;
    logic [ADDR_W-1:0] imem_wr_addr;
    logic [7:0]        imem_wr_data;

    modport master (
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  imem_wr_en,
        input  imem_wr_addr,
        input  imem_wr_data
    );

    modport slave (
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output imem_wr_en,
        output imem_wr_addr,
        output imem_wr_data
    );

endinterface

// File: rtl/imem_loader_timer.sv
// Inter-byte idle timer. Counts enabled cycles since the last clear and
// flags expiry on the TIMEOUT-th idle cycle so the FSM can abort on the
// following edge.
module loader_timer #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          at_limit;

    assign at_limit = (count_q == CW'(TIMEOUT - 1));
    assign expired  = enable && at_limit;

    // Next count: clear wins, otherwise advance while enabled and not yet at the limit.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !at_limit) begin
            count_d = count_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Program loader: receives a framed byte stream (sync, length, payload,
// checksum), writes each payload byte to instruction memory one cycle after
// it is accepted, and releases the core only after a frame verifies.
module imem_loader
    import loader_pkg::*;
#(
    parameter int         ADDR_W    = 8,
    parameter int         TIMEOUT   = 1024,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          cpu_run,
    output logic          load_done,
    output logic          load_err
);

    // Byte counter needs one extra bit so it can hold the full 2^ADDR_W length.
    localparam int CNT_W = ADDR_W + 1;

    loader_state_e      state_q, state_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CKSUM_W-1:0] sum_q, sum_d;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [7:0]         wr_data_q, wr_data_d;

    logic               rx_ready;
    logic               accept;
    logic               timed_state;
    logic               timer_clear;
    logic               timer_expired;
    logic [CKSUM_W-1:0] chk_total;
    logic [CNT_W-1:0]   cnt_inc;

    assign rx_ready    = (state_q == ST_SYNC) || (state_q == ST_LEN) ||
                         (state_q == ST_DATA) || (state_q == ST_CHK);
    assign accept      = bus.rx_valid && rx_ready;
    assign timed_state = (state_q == ST_LEN) || (state_q == ST_DATA) ||
                         (state_q == ST_CHK);
    // Outside the timed states the counter is held at zero, so it is
    // already clean on entry to LEN; later state entries coincide with an
    // accepted byte, which also clears it.
    assign timer_clear = accept || !timed_state;
    assign chk_total   = sum_q + bus.rx_data;
    assign cnt_inc     = cnt_q + CNT_W'(1);

    loader_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (timer_clear),
        .enable  (timed_state),
        .expired (timer_expired)
    );

    // Next-state, counters, checksum and write-port registers. An accepted
    // byte takes priority over a simultaneous timeout.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_SYNC;
                end
            end

            ST_SYNC: begin
                if (accept && (bus.rx_data == SYNC_BYTE)) begin
                    state_d = ST_LEN;
                end
            end

            ST_LEN: begin
                if (accept) begin
                    len_d   = CNT_W'(frame_len(bus.rx_data, ADDR_W));
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = ST_DATA;
                end else if (timer_expired) begin
                    state_d = ST_ERR;
                end
            end

            ST_DATA: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q[ADDR_W-1:0];
                    wr_data_d = bus.rx_data;
                    sum_d     = chk_total;
                    cnt_d     = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = ST_CHK;
                    end
                end else if (timer_expired) begin
                    state_d = ST_ERR;
                end
            end

            ST_CHK: begin
                if (accept) begin
                    state_d = (chk_total == '0) ? ST_DONE : ST_ERR;
                end else if (timer_expired) begin
                    state_d = ST_ERR;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            sum_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.rx_ready     = rx_ready;
    assign bus.imem_wr_en   = wr_en_q;
    assign bus.imem_wr_addr = wr_addr_q;
    assign bus.imem_wr_data = wr_data_q;

    // Status is a pure decode of the registered state, so run/done only rise
    // once the checksum byte has been accepted, after the last write.
    assign cpu_run   = (state_q == ST_DONE);
    assign load_done = (state_q == ST_DONE);
    assign load_err  = (state_q == ST_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader. Expected writes are queued as bytes
// are driven and checked by a monitor as the write port strobes.
module tb_imem_loader;

    logic clk;
    logic reset_n;
    logic start;
    logic cpu_run;
    logic load_done;
    logic load_err;

    int n_checks;
    int n_fail;
    int cyc;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        int         cyc;
    } wr_t;

    wr_t exp_q[$];

    imem_loader_if #(.ADDR_W(8)) bus ();

    imem_loader #(
        .ADDR_W    (8),
        .TIMEOUT   (16),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .bus       (bus),
        .cpu_run   (cpu_run),
        .load_done (load_done),
        .load_err  (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: every strobe must match the oldest expected write,
    // including the cycle it was predicted for (one edge after acceptance).
    always @(negedge clk) begin
        if (reset_n === 1'b1 && bus.imem_wr_en !== 1'b0) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got en=%b addr=%02h data=%02h at cycle %0d, expected no write",
                         bus.imem_wr_en, bus.imem_wr_addr, bus.imem_wr_data, cyc);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (bus.imem_wr_en !== 1'b1 || bus.imem_wr_addr !== e.addr ||
                    bus.imem_wr_data !== e.data || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL write: got %02h:%02h at cycle %0d, expected %02h:%02h at cycle %0d",
                             bus.imem_wr_addr, bus.imem_wr_data, cyc, e.addr, e.data, e.cyc);
                end else begin
                    $display("write %02h:%02h at cycle %0d", e.addr, e.data, cyc);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    // Drive one byte (after 'gap' idle cycles with rx_valid low), wait for it
    // to be accepted and queue the write it should produce.
    task automatic send_byte(input logic [7:0] b, input bit is_data,
                             input logic [7:0] a, input int gap);
        int waited;
        bus.rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        waited = 0;
        while (bus.rx_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (bus.rx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL accept: byte %02h not accepted, rx_ready=%b, expected 1", b, bus.rx_ready);
        end else if (is_data) begin
            exp_q.push_back('{addr: a, data: b, cyc: cyc + 1});
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_drained(input string name);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_writes: %0d expected writes missing, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_status(input string name, input logic run_e,
                                input logic done_e, input logic err_e);
        n_checks++;
        if (cpu_run !== run_e || load_done !== done_e || load_err !== err_e) begin
            n_fail++;
            $display("FAIL %s_status: run/done/err=%b%b%b, expected %b%b%b",
                     name, cpu_run, load_done, load_err, run_e, done_e, err_e);
        end else begin
            $display("%s status run/done/err=%b%b%b", name, cpu_run, load_done, load_err);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'h00;
        #12;
        n_checks++;
        if (bus.rx_ready !== 1'b0 || bus.imem_wr_en !== 1'b0 || bus.imem_wr_addr !== 8'h00 ||
            bus.imem_wr_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_port: rdy=%b en=%b addr=%02h data=%02h, expected 0 0 00 00",
                     bus.rx_ready, bus.imem_wr_en, bus.imem_wr_addr, bus.imem_wr_data);
        end
        check_status("reset", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_good_frame();
        pulse_start();
        send_byte(8'hA5, 0, 8'h00, 0);
        send_byte(8'h03, 0, 8'h00, 0);
        send_byte(8'h40, 1, 8'h00, 0);
        send_byte(8'h55, 1, 8'h01, 0);
        send_byte(8'h6A, 1, 8'h02, 0);
        check_status("good_pre", 1'b0, 1'b0, 1'b0);
        send_byte(8'h01, 0, 8'h00, 0);
        check_status("good", 1'b1, 1'b1, 1'b0);
        check_drained("good");
    endtask

    task automatic test_bad_checksum();
        pulse_start();
        check_status("restart", 1'b0, 1'b0, 1'b0);
        send_byte(8'hA5, 0, 8'h00, 0);
        send_byte(8'h02, 0, 8'h00, 0);
        send_byte(8'h10, 1, 8'h00, 0);
        send_byte(8'h20, 1, 8'h01, 0);
        send_byte(8'h00, 0, 8'h00, 0);
        check_status("badsum", 1'b0, 1'b0, 1'b1);
        check_drained("badsum");
    endtask

    task automatic test_sync_backpressure();
        logic [7:0] bytes [6];
        bytes = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7F, 8'h81};
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            send_byte(bytes[i], (i == 4), 8'h00, $urandom_range(0, 2));
        end
        check_status("sync", 1'b1, 1'b1, 1'b0);
        check_drained("sync");
    endtask

    task automatic test_timeout();
        pulse_start();
        send_byte(8'hA5, 0, 8'h00, 0);
        send_byte(8'h04, 0, 8'h00, 0);
        send_byte(8'h11, 1, 8'h00, 0);
        repeat (15) @(negedge clk);
        check_status("timeout_pre", 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (bus.rx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_pre_ready: rx_ready=%b, expected 1", bus.rx_ready);
        end
        @(negedge clk);
        check_status("timeout", 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (bus.rx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_ready: rx_ready=%b, expected 0", bus.rx_ready);
        end
        check_drained("timeout");
    endtask

    task automatic test_reset_mid_frame();
        pulse_start();
        send_byte(8'hA5, 0, 8'h00, 0);
        send_byte(8'h05, 0, 8'h00, 0);
        send_byte(8'h21, 1, 8'h00, 0);
        send_byte(8'h22, 1, 8'h01, 0);
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (bus.rx_ready !== 1'b0 || bus.imem_wr_en !== 1'b0 || bus.imem_wr_addr !== 8'h00 ||
            bus.imem_wr_data !== 8'h00) begin
            n_fail++;
            $display("FAIL midreset_port: rdy=%b en=%b addr=%02h data=%02h, expected 0 0 00 00",
                     bus.rx_ready, bus.imem_wr_en, bus.imem_wr_addr, bus.imem_wr_data);
        end
        check_status("midreset", 1'b0, 1'b0, 1'b0);
        check_drained("midreset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        pulse_start();
        send_byte(8'hA5, 0, 8'h00, 0);
        send_byte(8'h02, 0, 8'h00, 0);
        send_byte(8'h33, 1, 8'h00, 0);
        send_byte(8'h44, 1, 8'h01, 0);
        send_byte(8'h89, 0, 8'h00, 0);
        check_status("after_reset", 1'b1, 1'b1, 1'b0);
        check_drained("after_reset");
    endtask

    task automatic test_full_length();
        logic [7:0] sum;
        logic [7:0] b;
        sum = 8'h00;
        pulse_start();
        send_byte(8'hA5, 0, 8'h00, 0);
        send_byte(8'h00, 0, 8'h00, 0);
        for (int i = 0; i < 256; i++) begin
            b = 8'(i);
            sum = sum + b;
            send_byte(b, 1, b, 0);
        end
        send_byte(8'h00 - sum, 0, 8'h00, 0);
        check_status("full", 1'b1, 1'b1, 1'b0);
        check_drained("full");
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        cyc = 0;
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_sync_backpressure();
        test_timeout();
        test_reset_mid_frame();
        test_full_length();
        repeat (3) @(negedge clk);
        check_drained("final");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
